// File: rtl/out_writeback_pkg.sv
// Shared types for the output writeback block: address modes and controller states.
package out_writeback_pkg;

   typedef enum logic [1:0] {
      ModeDescStride = 2'd0,
      ModeConvPlane  = 2'd1,
      ModeAscStride  = 2'd2,
      ModeReserved   = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StDrain = 2'd2,
      StDone  = 2'd3
   } state_e;

endpackage

// File: rtl/out_writeback_fifo.sv
// Synchronous FIFO buffering {mask, data} rows between the input and the BRAM write port.
module wb_fifo #(
   parameter int unsigned WIDTH = 36,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PtrW = $clog2(DEPTH);

   logic [PtrW:0]    wr_ptr_q, rd_ptr_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                    (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem_q[rd_ptr_q[PtrW-1:0]];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[PtrW-1:0]] <= wdata;
   end

endmodule

// File: rtl/out_writeback.sv
// Output writeback: buffers result rows and writes them to BRAM along a strided/plane sequence.
module out_writeback
   import out_writeback_pkg::*;
#(
   parameter int unsigned MAT_MUL_SIZE = 4,
   parameter int unsigned DWIDTH       = 8,
   parameter int unsigned AWIDTH       = 10,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic                           clk,
   input  logic                           resetn,
   input  logic                           start,
   input  logic [1:0]                     mode,
   input  logic [AWIDTH-1:0]              base_addr,
   input  logic [AWIDTH-1:0]              addr_stride,
   input  logic [15:0]                    out_img_height,
   input  logic [15:0]                    out_img_width,
   input  logic [15:0]                    num_rows,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [MAT_MUL_SIZE*DWIDTH-1:0] in_data,
   input  logic [MAT_MUL_SIZE-1:0]        validity_mask,
   input  logic                           wr_grant,
   output logic [AWIDTH-1:0]              bram_addr,
   output logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_wdata,
   output logic [MAT_MUL_SIZE-1:0]        bram_we,
   output logic                           busy,
   output logic                           done,
   output logic                           cfg_err
);

   localparam int unsigned RowW = MAT_MUL_SIZE * DWIDTH;
   localparam int unsigned EntW = MAT_MUL_SIZE * (DWIDTH + 1);

   state_e                  state_q, state_d;
   mode_e                   mode_q, mode_d;
   logic [AWIDTH-1:0]       stride_q, stride_d;
   logic [AWIDTH-1:0]       plane_q, plane_d;
   logic [AWIDTH-1:0]       cur_addr_q, cur_addr_d;
   logic [15:0]             num_rows_q, num_rows_d;
   logic [15:0]             acc_q, acc_d;
   logic [15:0]             wr_q, wr_d;
   logic                    cfg_err_q, cfg_err_d;
   logic [AWIDTH-1:0]       bram_addr_q, bram_addr_d;
   logic [RowW-1:0]         bram_wdata_q, bram_wdata_d;
   logic [MAT_MUL_SIZE-1:0] bram_we_q, bram_we_d;

   logic                    push, pop;
   logic                    fifo_full, fifo_empty;
   logic [EntW-1:0]         fifo_rdata;
   logic [MAT_MUL_SIZE-1:0] head_mask;
   logic [RowW-1:0]         head_data, head_masked;
   logic [AWIDTH-1:0]       plane_in;
   logic [AWIDTH-1:0]       next_addr;

   assign plane_in  = AWIDTH'({16'd0, out_img_height} * {16'd0, out_img_width});
   assign in_ready  = (state_q == StRun) && !fifo_full && (acc_q < num_rows_q);
   assign push      = in_valid && in_ready;
   assign pop       = !fifo_empty && wr_grant && ((state_q == StRun) || (state_q == StDrain));
   assign head_mask = fifo_rdata[EntW-1:RowW];
   assign head_data = fifo_rdata[RowW-1:0];

   wb_fifo #(
      .WIDTH (EntW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (push),
      .wdata  ({validity_mask, in_data}),
      .pop    (pop),
      .rdata  (fifo_rdata),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   always_comb begin
      head_masked = '0;
      for (int i = 0; i < int'(MAT_MUL_SIZE); i++) begin
         head_masked[i*DWIDTH +: DWIDTH] = head_data[i*DWIDTH +: DWIDTH] & {DWIDTH{head_mask[i]}};
      end
   end

   always_comb begin
      next_addr = cur_addr_q;
      case (mode_q)
         ModeDescStride: next_addr = cur_addr_q - stride_q;
         ModeConvPlane:  next_addr = cur_addr_q + plane_q;
         ModeAscStride:  next_addr = cur_addr_q + stride_q;
         default:        next_addr = cur_addr_q;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      mode_d       = mode_q;
      stride_d     = stride_q;
      plane_d      = plane_q;
      cur_addr_d   = cur_addr_q;
      num_rows_d   = num_rows_q;
      acc_d        = acc_q;
      wr_d         = wr_q;
      cfg_err_d    = cfg_err_q;
      bram_addr_d  = bram_addr_q;
      bram_wdata_d = bram_wdata_q;
      bram_we_d    = '0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (mode == 2'd3) begin
                  cfg_err_d = 1'b1;
               end else begin
                  cfg_err_d  = 1'b0;
                  mode_d     = mode_e'(mode);
                  stride_d   = addr_stride;
                  plane_d    = plane_in;
                  cur_addr_d = base_addr;
                  num_rows_d = num_rows;
                  acc_d      = '0;
                  wr_d       = '0;
                  state_d    = (num_rows == 16'd0) ? StDone : StRun;
               end
            end
         end
         StRun: begin
            acc_d = acc_q + 16'(push);
            if (acc_d == num_rows_q) state_d = StDrain;
         end
         StDrain: begin
            if (fifo_empty && (wr_q == num_rows_q)) state_d = StDone;
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase

      // All-zero-mask rows still take an address slot; they just never enable a lane.
      if (pop) begin
         bram_addr_d  = cur_addr_q;
         bram_we_d    = head_mask;
         bram_wdata_d = head_masked;
         wr_d         = wr_q + 16'd1;
         cur_addr_d   = next_addr;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mode_q       <= ModeDescStride;
         stride_q     <= '0;
         plane_q      <= '0;
         cur_addr_q   <= '0;
         num_rows_q   <= '0;
         acc_q        <= '0;
         wr_q         <= '0;
         cfg_err_q    <= 1'b0;
         bram_addr_q  <= '0;
         bram_wdata_q <= '0;
         bram_we_q    <= '0;
      end else begin
         mode_q       <= mode_d;
         stride_q     <= stride_d;
         plane_q      <= plane_d;
         cur_addr_q   <= cur_addr_d;
         num_rows_q   <= num_rows_d;
         acc_q        <= acc_d;
         wr_q         <= wr_d;
         cfg_err_q    <= cfg_err_d;
         bram_addr_q  <= bram_addr_d;
         bram_wdata_q <= bram_wdata_d;
         bram_we_q    <= bram_we_d;
      end
   end

   assign bram_addr  = bram_addr_q;
   assign bram_wdata = bram_wdata_q;
   assign bram_we    = bram_we_q;
   assign busy       = (state_q != StIdle);
   assign done       = (state_q == StDone);
   assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_out_writeback.sv
// Directed bench for out_writeback: table-driven single-job vectors plus multi-cycle corner sequences.
module tb_out_writeback;

   logic        clk = 1'b0;
   logic        resetn;
   logic        start;
   logic [1:0]  mode;
   logic [9:0]  base_addr, addr_stride;
   logic [15:0] out_img_height, out_img_width, num_rows;
   logic        in_valid, in_ready;
   logic [31:0] in_data;
   logic [3:0]  validity_mask;
   logic        wr_grant;
   logic [9:0]  bram_addr;
   logic [31:0] bram_wdata;
   logic [3:0]  bram_we;
   logic        busy, done, cfg_err;

   int passed = 0;
   int total  = 0;

   typedef struct {
      logic [1:0]       mode;
      logic [9:0]       base;
      logic [9:0]       stride;
      logic [15:0]      h;
      logic [15:0]      w;
      int               n;
      logic [3:0]       mask;
      logic [31:0]      data;
      logic [3:0][9:0]  addrs;
      logic [3:0]       we;
      logic [31:0]      wdata;
   } vec_t;

   vec_t vecs [5];

   out_writeback #(
      .MAT_MUL_SIZE (4),
      .DWIDTH       (8),
      .AWIDTH       (10),
      .FIFO_DEPTH   (4)
   ) dut (
      .clk            (clk),
      .resetn         (resetn),
      .start          (start),
      .mode           (mode),
      .base_addr      (base_addr),
      .addr_stride    (addr_stride),
      .out_img_height (out_img_height),
      .out_img_width  (out_img_width),
      .num_rows       (num_rows),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .validity_mask  (validity_mask),
      .wr_grant       (wr_grant),
      .bram_addr      (bram_addr),
      .bram_wdata     (bram_wdata),
      .bram_we        (bram_we),
      .busy           (busy),
      .done           (done),
      .cfg_err        (cfg_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [31:0] make_row(input int k);
      return 32'h01010101 * 32'(k + 1);
   endfunction

   // Back-to-back rows with wr_grant held high: row j is pushed at edge j+1 and written at j+2.
   task automatic run_vec(input int v);
      vec_t t;
      t = vecs[v];
      @(negedge clk);
      mode           = t.mode;
      base_addr      = t.base;
      addr_stride    = t.stride;
      out_img_height = t.h;
      out_img_width  = t.w;
      num_rows       = 16'(t.n);
      in_data        = t.data;
      validity_mask  = t.mask;
      wr_grant       = 1'b1;
      start          = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
      for (int cyc = 1; cyc <= t.n + 3; cyc++) begin
         @(negedge clk);
         in_valid = (cyc <= t.n);
         if (cyc <= t.n)     chk("in_ready_run", 32'(in_ready), 32'd1);
         if (cyc == t.n + 1) chk("in_ready_drain", 32'(in_ready), 32'd0);
         @(posedge clk);
         #1;
         if (cyc >= 2 && cyc <= t.n + 1) begin
            chk("wr_addr", 32'(bram_addr), 32'(t.addrs[cyc-2]));
            chk("wr_we", 32'(bram_we), 32'(t.we));
            chk("wr_wdata", bram_wdata, t.wdata);
         end else begin
            chk("idle_we", 32'(bram_we), 32'd0);
         end
         chk("done_pulse", 32'(done), 32'(cyc == t.n + 2));
      end
      chk("busy_end", 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  acc, nw;
      bit  done_seen;

      vecs[0] = '{2'd0, 10'd100, 10'd4, 16'd0, 16'd0, 3, 4'hF, 32'h44332211,
                  {10'd0, 10'd92, 10'd96, 10'd100}, 4'hF, 32'h44332211};
      vecs[1] = '{2'd1, 10'd8, 10'd0, 16'd2, 16'd3, 4, 4'hF, 32'hDEADBEEF,
                  {10'd26, 10'd20, 10'd14, 10'd8}, 4'hF, 32'hDEADBEEF};
      vecs[2] = '{2'd2, 10'd1022, 10'd3, 16'd0, 16'd0, 3, 4'h5, 32'h44332211,
                  {10'd0, 10'd4, 10'd1, 10'd1022}, 4'h5, 32'h00330011};
      vecs[3] = '{2'd0, 10'd2, 10'd5, 16'd0, 16'd0, 2, 4'h0, 32'h12345678,
                  {10'd0, 10'd0, 10'd1021, 10'd2}, 4'h0, 32'h00000000};
      vecs[4] = '{2'd1, 10'd0, 10'd0, 16'd40, 16'd30, 2, 4'hA, 32'hAABBCCDD,
                  {10'd0, 10'd0, 10'd176, 10'd0}, 4'hA, 32'hAA00CC00};

      resetn = 1'b0; start = 1'b0; mode = 2'd0; base_addr = '0; addr_stride = '0;
      out_img_height = '0; out_img_width = '0; num_rows = '0; in_valid = 1'b0;
      in_data = '0; validity_mask = '0; wr_grant = 1'b0;
      #3;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_cfg_err", 32'(cfg_err), 32'd0);
      chk("rst_we", 32'(bram_we), 32'd0);
      chk("rst_addr", 32'(bram_addr), 32'd0);
      chk("rst_wdata", bram_wdata, 32'd0);
      @(negedge clk);
      resetn = 1'b1;

      for (int v = 0; v < 5; v++) run_vec(v);

      // Reserved mode flags cfg_err; the next accepted start (zero rows) clears it.
      @(negedge clk);
      mode = 2'd3; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      chk("cfg_err_set", 32'(cfg_err), 32'd1);
      chk("cfg_err_busy", 32'(busy), 32'd0);
      chk("cfg_err_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      mode = 2'd0; num_rows = 16'd0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      chk("cfg_err_clear", 32'(cfg_err), 32'd0);
      chk("zero_rows_done", 32'(done), 32'd1);
      chk("zero_rows_busy", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      chk("zero_rows_done_off", 32'(done), 32'd0);
      chk("zero_rows_idle", 32'(busy), 32'd0);

      // Back-pressure: no grant, six rows, four-deep FIFO.
      @(negedge clk);
      mode = 2'd2; base_addr = 10'd0; addr_stride = 10'd1; num_rows = 16'd6;
      validity_mask = 4'hF; wr_grant = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      acc = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         in_data  = make_row(acc);
         in_valid = (acc < 6);
         if (in_ready && in_valid) acc++;
      end
      chk("bp_accepts", 32'(acc), 32'd4);
      chk("bp_in_ready_full", 32'(in_ready), 32'd0);
      chk("bp_no_write", 32'(bram_we), 32'd0);
      wr_grant  = 1'b1;
      nw        = 0;
      done_seen = 1'b0;
      for (int c = 0; c < 40 && !done_seen; c++) begin
         @(negedge clk);
         if (bram_we != 4'h0) begin
            chk("bp_addr", 32'(bram_addr), 32'(nw));
            chk("bp_data", bram_wdata, make_row(nw));
            nw++;
         end
         if (done) done_seen = 1'b1;
         in_data  = make_row(acc);
         in_valid = (acc < 6);
         if (in_ready && in_valid) acc++;
      end
      in_valid = 1'b0;
      chk("bp_total_accepts", 32'(acc), 32'd6);
      chk("bp_total_writes", 32'(nw), 32'd6);
      chk("bp_done_seen", 32'(done_seen), 32'd1);

      // Reset in DRAIN with two rows buffered.
      @(negedge clk);
      mode = 2'd0; base_addr = 10'd50; addr_stride = 10'd1; num_rows = 16'd2;
      wr_grant = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         in_data  = make_row(c);
         in_valid = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      chk("drain_busy", 32'(busy), 32'd1);
      chk("drain_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      wr_grant = 1'b1;
      resetn   = 1'b0;
      #1;
      chk("midrst_we", 32'(bram_we), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("rst_hold_we", 32'(bram_we), 32'd0);
      end
      resetn = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("post_rst_we", 32'(bram_we), 32'd0);
         chk("post_rst_done", 32'(done), 32'd0);
         chk("post_rst_busy", 32'(busy), 32'd0);
      end
      run_vec(0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
